// File: rtl/wb_commit_queue.sv
// Writeback commit queue: merges ALU and LSU results round-robin into a small FIFO
// and drains one register-file write per cycle. Define WB_BYPASS_EN for same-cycle bypass.
module wb_commit_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [4:0]    lsu_rd,
    input  logic [31:0]   lsu_data,
    input  logic          flush,
    input  logic          rf_hold,
    output logic          rf_we,
    output logic [4:0]    rf_addr,
    output logic [31:0]   rf_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    logic [CW-1:0] r_count;
    logic          r_pref;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    wb_entry_t     r_mem [DEPTH];

    logic [CW-1:0] w_free;
    logic          w_alu_xfer;
    logic          w_lsu_xfer;
    wb_entry_t     w_alu_res;
    wb_entry_t     w_lsu_res;
    wb_entry_t     w_first;
    wb_entry_t     w_second;
    logic          w_first_keep;
    logic          w_second_keep;
    wb_entry_t     w_c0;
    wb_entry_t     w_c1;
    logic          w_c0_valid;
    logic          w_c1_valid;
    wb_entry_t     w_st0;
    wb_entry_t     w_st1;
    logic          w_st0_valid;
    logic          w_st1_valid;
    logic          w_bypass;
    logic          w_deq;
    logic [CW-1:0] w_n_enq;
    wb_entry_t     w_head;

    // Readiness looks only at registered occupancy and pointer plus flush/reset,
    // so producers never see a ready that depends on their own valid.
    assign w_free    = DEPTH_C - r_count;
    assign alu_ready = !reset && !flush &&
                       ((w_free >= CW'(2)) || ((w_free == CW'(1)) && r_pref));
    assign lsu_ready = !reset && !flush &&
                       ((w_free >= CW'(2)) || ((w_free == CW'(1)) && !r_pref));

    assign w_alu_xfer = alu_valid && alu_ready;
    assign w_lsu_xfer = lsu_valid && lsu_ready;
    assign w_alu_res  = '{rd: alu_rd, data: alu_data};
    assign w_lsu_res  = '{rd: lsu_rd, data: lsu_data};

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that leaves one unassigned infers a latch.
        w_first       = w_lsu_res;
        w_second      = w_alu_res;
        w_first_keep  = 1'b0;
        w_second_keep = 1'b0;
        if (w_alu_xfer && w_lsu_xfer) begin
            if (r_pref) begin
                w_first  = w_alu_res;
                w_second = w_lsu_res;
            end
            w_first_keep  = (w_first.rd != 5'd0);
            w_second_keep = (w_second.rd != 5'd0);
        end else if (w_alu_xfer) begin
            w_first      = w_alu_res;
            w_first_keep = (alu_rd != 5'd0);
        end else if (w_lsu_xfer) begin
            w_first_keep = (lsu_rd != 5'd0);
        end
    end

    // Squeeze out x0 results so stored entries are always contiguous.
    always_comb begin
        w_c0       = w_first;
        w_c0_valid = w_first_keep;
        w_c1       = w_second;
        w_c1_valid = w_second_keep && w_first_keep;
        if (!w_first_keep) begin
            w_c0       = w_second;
            w_c0_valid = w_second_keep;
        end
    end

`ifdef WB_BYPASS_EN
    assign w_bypass = (r_count == '0) && !rf_hold && !flush && !reset && w_c0_valid;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_st0       = w_c0;
        w_st0_valid = w_c0_valid;
        w_st1       = w_c1;
        w_st1_valid = w_c1_valid;
        if (w_bypass) begin
            w_st0       = w_c1;
            w_st0_valid = w_c1_valid;
            w_st1_valid = 1'b0;
        end
    end

    assign w_n_enq = CW'(w_st0_valid) + CW'(w_st1_valid);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_deq   = (r_count != '0) && !rf_hold && !flush && !reset;

    always_comb begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (w_deq) begin
            rf_we   = 1'b1;
            rf_addr = w_head.rd;
            rf_data = w_head.data;
        end
`ifdef WB_BYPASS_EN
        else if (w_bypass) begin
            rf_we   = 1'b1;
            rf_addr = w_c0.rd;
            rf_data = w_c0.data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_count  <= '0;
            r_pref   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_alu_xfer ^ w_lsu_xfer) begin
                r_pref <= !r_pref;
            end
            r_count  <= r_count + w_n_enq - CW'(w_deq);
            r_wr_ptr <= r_wr_ptr + AW'(w_n_enq);
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: entry storage has no reset; occupancy alone decides which slots are live.
        if (w_st0_valid) begin
            r_mem[r_wr_ptr] <= w_st0;
        end
        if (w_st1_valid) begin
            r_mem[r_wr_ptr + AW'(1)] <= w_st1;
        end
    end

    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == DEPTH_C);

    a_count_bound: assert property (@(posedge clk) disable iff (reset) r_count <= DEPTH_C);
    a_no_x0_write: assert property (@(posedge clk) disable iff (reset) rf_we |-> (rf_addr != 5'd0));

endmodule

// File: tb/tb_wb_commit_queue.sv
// Scoreboard bench for wb_commit_queue: a queue-level model predicts readies,
// occupancy and the register-file write stream; a monitor checks the writes.
module tb_wb_commit_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_rd;
    logic [31:0]   lsu_data;
    logic          flush;
    logic          rf_hold;
    logic          rf_we;
    logic [4:0]    rf_addr;
    logic [31:0]   rf_data;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    wb_commit_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .flush     (flush),
        .rf_hold   (rf_hold),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    int  n_vec = 0;
    int  n_err = 0;
    wr_t m_q[$];
    wr_t sb_q[$];
    bit  m_pref = 1'b0;

    bit          a_req  = 1'b0;
    bit          l_req  = 1'b0;
    logic [4:0]  a_rd   = 5'd0;
    logic [4:0]  l_rd   = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic [31:0] l_data = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cycle(input bit rst, input bit fl, input bit hold);
        int  free;
        bit  er_a, er_l, xa, xl, was_empty, byp_used;
        wr_t acc[$];
        wr_t ra, rl;
        @(negedge clk);
        reset     = rst;
        flush     = fl;
        rf_hold   = hold;
        alu_valid = a_req;
        alu_rd    = a_rd;
        alu_data  = a_data;
        lsu_valid = l_req;
        lsu_rd    = l_rd;
        lsu_data  = l_data;
        #1;
        if (rst) begin
            check("alu_ready_in_reset", 32'(alu_ready), 32'd0);
            check("lsu_ready_in_reset", 32'(lsu_ready), 32'd0);
            m_q.delete();
            m_pref = 1'b0;
            return;
        end
        check("count", 32'(count), 32'(m_q.size()));
        check("empty", 32'(empty), 32'(m_q.size() == 0));
        check("full",  32'(full),  32'(m_q.size() == DEPTH));
        free = DEPTH - m_q.size();
        er_a = !fl && (free >= 2 || (free == 1 && m_pref));
        er_l = !fl && (free >= 2 || (free == 1 && !m_pref));
        check("alu_ready", 32'(alu_ready), 32'(er_a));
        check("lsu_ready", 32'(lsu_ready), 32'(er_l));
        xa = a_req && er_a;
        xl = l_req && er_l;
        ra = '{rd: a_rd, data: a_data};
        rl = '{rd: l_rd, data: l_data};
        if (fl) begin
            m_q.delete();
        end else begin
            was_empty = (m_q.size() == 0);
            byp_used  = 1'b0;
            if (!was_empty && !hold) sb_q.push_back(m_q.pop_front());
            if (xa && xl) begin
                if (m_pref) begin acc.push_back(ra); acc.push_back(rl); end
                else        begin acc.push_back(rl); acc.push_back(ra); end
            end else if (xa) begin
                acc.push_back(ra);
            end else if (xl) begin
                acc.push_back(rl);
            end
            foreach (acc[i]) begin
                if (acc[i].rd != 5'd0) begin
`ifdef WB_BYPASS_EN
                    if (was_empty && !hold && !byp_used) begin
                        sb_q.push_back(acc[i]);
                        byp_used = 1'b1;
                    end else
`endif
                    m_q.push_back(acc[i]);
                end
            end
        end
        if (xa ^ xl) m_pref = !m_pref;
        if (xa) a_req = 1'b0;
        if (xl) l_req = 1'b0;
    endtask

    task automatic new_reqs(input int pct, input bit nonzero);
        if (!a_req && $urandom_range(99) < pct) begin
            a_req  = 1'b1;
            a_rd   = (!nonzero && $urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            a_data = $urandom;
        end
        if (!l_req && $urandom_range(99) < pct) begin
            l_req  = 1'b1;
            l_rd   = (!nonzero && $urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            l_data = $urandom;
        end
    endtask

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            #3;
            if (reset === 1'b0) begin
                if (rf_we === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rf_unexpected_write: got rd=%0d data=%h, expected no write", rf_addr, rf_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("rf_addr", 32'(rf_addr), 32'(e.rd));
                        check("rf_data", rf_data, e.data);
                    end
                end else begin
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        n_vec++;
                        n_err++;
                        $display("FAIL rf_missing_write: got rf_we=%b, expected write rd=%0d data=%h", rf_we, e.rd, e.data);
                    end
                    check("rf_idle_addr", 32'(rf_addr), 32'd0);
                    check("rf_idle_data", rf_data, 32'd0);
                end
            end
        end
    end

    initial begin : stim
        reset     = 1'b1;
        flush     = 1'b0;
        rf_hold   = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        lsu_valid = 1'b0;
        lsu_rd    = 5'd0;
        lsu_data  = 32'd0;
        repeat (3) cycle(1'b1, 1'b0, 1'b0);

        // Single ALU result
        a_req = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);

        // LSU x0 result: handshake only (also returns pref to LSU)
        l_req = 1'b1; l_rd = 5'd0; l_data = 32'h55;
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // Dual accept with LSU preferred
        a_req = 1'b1; a_rd = 5'd3; a_data = 32'h11;
        l_req = 1'b1; l_rd = 5'd4; l_data = 32'h22;
        repeat (4) cycle(1'b0, 1'b0, 1'b0);

        // Fill under rf_hold, then release
        for (int i = 0; i < 5; i++) begin
            new_reqs(100, 1'b1);
            cycle(1'b0, 1'b0, 1'b1);
        end
        repeat (10) cycle(1'b0, 1'b0, 1'b0);

        // Three entries queued, then flush
        new_reqs(100, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        a_req = 1'b1; a_rd = 5'd9; a_data = 32'h99;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // Reset with two entries queued and producers still requesting
        new_reqs(100, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        new_reqs(100, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rs, fl, hd;
            new_reqs(60, 1'b0);
            hd = ($urandom_range(3) == 0);
            fl = ($urandom_range(39) == 0);
            rs = ($urandom_range(199) == 0);
            cycle(rs, fl, hd);
        end

        // Drain everything still pending
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #4;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("model_drained", 32'(m_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Writeback commit queue sitting between the execution units (ALU and load/store unit) and the write port (port 2) of the integer architectural register file. Accepts up to two results per cycle over valid/ready handshakes, orders them round-robin, buffers them in a small FIFO, and drains one register write per cycle onto the register file write port. Its writes are what set the register file's valid bits, so it is the producer side of the source-ready scoreboard.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CW, $clog2(DEPTH+1), width of `count`.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  queue accepts ALU result this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- lsu_valid  in  1  LSU result valid.
- lsu_ready  out  1  queue accepts LSU result this cycle.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  32  LSU load data.
- flush  in  1  discard all queued entries.
- rf_hold  in  1  suppress draining this cycle.
- rf_we  out  1  register file write enable (port 2).
- rf_addr  out  5  register file write address.
- rf_data  out  32  register file write data.
- count  out  CW  occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- Handshake: transfer when valid && ready on rising clk. ready depends only on registered state (count, pref, flush), never on valid; producers must hold valid/rd/data stable until transfer.
- free = DEPTH − count. free ≥ 2: both readies high. free == 1: only the source selected by `pref` is ready. free == 0, flush or reset: both low.
- pref: 1-bit round-robin pointer, 0 = LSU preferred, 1 = ALU preferred. Reset value 0. After any cycle with exactly one transfer, pref points to the other source; two transfers leave pref unchanged.
- Ordering: with two transfers in one cycle, the preferred source is enqueued first (written first). Same rd from both: both writes issued in order; the later one wins.
- rd == 0: handshake completes, no entry enqueued, no write issued, count unchanged by it.
- Drain: when !empty && !rf_hold, head drives rf_we=1, rf_addr/rf_data = head entry; head pops at the clock edge. Empty or rf_hold: rf_we=0, rf_addr=0, rf_data=0.
- Enqueue and dequeue in the same cycle are legal; count_next = count + enq(0..2) − deq(0..1).
- Pointers wrap modulo DEPTH.
- flush: at the edge, count, pointers and storage valid are cleared; no write issued during the flush cycle (rf_we=0). pref unchanged.
- reset dominates flush and everything else; mid-operation reset discards all entries.

## Timing
- Reset values: alu_ready=0, lsu_ready=0 during reset; afterwards count=0, empty=1, full=0, rf_we=0, rf_addr=0, rf_data=0, pref=0.
- Latency (default build): result accepted at edge N appears on rf port in cycle N+1 if it reaches head and rf_hold=0; the second result of a dual accept appears in N+2.
- Throughput: 2 enqueues/cycle peak, 1 drain/cycle sustained.
- rf_* outputs are driven from flops (head entry storage), no combinational path from producer inputs unless WB_BYPASS_EN.

## Configuration
- WB_BYPASS_EN defined: when empty && !rf_hold && !flush, the first-ordered accepted non-x0 result drives rf_we/rf_addr/rf_data combinationally in the same cycle and is not stored; a second result of the same cycle is enqueued. Latency 0 cycles for that result.
- WB_BYPASS_EN undefined: no bypass; minimum latency 1 cycle as above.

## Test plan
- Single ALU result rd=5, data=0xDEADBEEF after reset -> rf_we=1, rf_addr=5, rf_data=0xDEADBEEF one cycle later (same cycle with WB_BYPASS_EN); count returns to 0.
- Simultaneous ALU rd=3/0x11 and LSU rd=4/0x22, pref=0 -> writes rd=4/0x22 then rd=3/0x11 on consecutive cycles; pref stays 0.
- rf_hold=1, both sources valid every cycle with DEPTH=4 -> accepts 2,2 then full=1, both readies 0; with count=3 only preferred source ready; release hold -> 4 writes in enqueue order.
- LSU result rd=0, data=0x55 -> lsu_ready transfer completes, count stays 0, rf_we stays 0.
- Queue holding 3 entries, assert flush for one cycle -> rf_we=0 that cycle, count=0 and empty=1 next cycle, no further writes.
- Reset asserted with 2 entries queued -> readies 0 during reset; after release count=0, rf_we=0, pref=0.
